multi_corner_tracker: RTL

MULTI_CORNER_TRACKER -- requirements
Module: multi_corner_tracker

---
 rtl/corner_pkg.sv | 31 +++
 rtl/color_dist_pipe.sv | 62 ++++++
 rtl/multi_corner_tracker.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/corner_pkg.sv
// Shared constants and types for the multi-corner colour tracker.
// Holds the RGB field layout, the per-stage datapath widths, the frame FSM
// state type and a small helper for the squaring stage.
package corner_pkg;

  // Colour field layout of one packed 24-bit target (R in the MSB byte).
  localparam int unsigned COLOR_W = 8;
  localparam int unsigned RGB_W   = 24;
  localparam int unsigned R_LSB   = 16;
  localparam int unsigned G_LSB   = 8;
  localparam int unsigned B_LSB   = 0;

  // Datapath widths of the three distance stages.
  localparam int unsigned DIFF_W = 9;   // signed colour difference
  localparam int unsigned SQ_W   = 16;  // unsigned square of one difference
  localparam int unsigned SUM_W  = 18;  // sum of three squares, also threshold width

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccum   = 2'd1,
    StPublish = 2'd2
  } corner_state_e;

  // |d| <= 255, so the square always fits in SQ_W bits.
  function automatic logic [SQ_W-1:0] square_diff(input logic signed [DIFF_W-1:0] d);
    logic signed [2*DIFF_W-1:0] p;
    p = (2*DIFF_W)'(d) * (2*DIFF_W)'(d);
    return p[SQ_W-1:0];
  endfunction

endpackage

// File: rtl/color_dist_pipe.sv
// Three-stage squared colour distance compare for one tracker channel.
// Stage 1 registers the signed per-colour differences and the threshold,
// stage 2 the squares, stage 3 the strict compare sum < threshold.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   r, g, b             pixel colour
//   target              packed target colour {R, G, B}
//   threshold           squared-distance threshold, sampled with the pixel
//   hit                 stage-3 compare result (ungated by valid)
module color_dist_pipe
  import corner_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] r,
  input  logic [COLOR_W-1:0] g,
  input  logic [COLOR_W-1:0] b,
  input  logic [RGB_W-1:0]   target,
  input  logic [SUM_W-1:0]   threshold,
  output logic               hit
);

  logic signed [DIFF_W-1:0] diff_r_d, diff_g_d, diff_b_d;
  logic signed [DIFF_W-1:0] diff_r_q, diff_g_q, diff_b_q;
  logic [SQ_W-1:0]          sq_r_q, sq_g_q, sq_b_q;
  logic [SUM_W-1:0]         thr1_q, thr2_q;
  logic [SUM_W-1:0]         sum;
  logic                     hit_q;

  assign diff_r_d = $signed({1'b0, r}) - $signed({1'b0, target[R_LSB +: COLOR_W]});
  assign diff_g_d = $signed({1'b0, g}) - $signed({1'b0, target[G_LSB +: COLOR_W]});
  assign diff_b_d = $signed({1'b0, b}) - $signed({1'b0, target[B_LSB +: COLOR_W]});

  assign sum = SUM_W'(sq_r_q) + SUM_W'(sq_g_q) + SUM_W'(sq_b_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      diff_r_q <= '0;
      diff_g_q <= '0;
      diff_b_q <= '0;
      thr1_q   <= '0;
      sq_r_q   <= '0;
      sq_g_q   <= '0;
      sq_b_q   <= '0;
      thr2_q   <= '0;
      hit_q    <= 1'b0;
    end else begin
      diff_r_q <= diff_r_d;
      diff_g_q <= diff_g_d;
      diff_b_q <= diff_b_d;
      thr1_q   <= threshold;
      sq_r_q   <= square_diff(diff_r_q);
      sq_g_q   <= square_diff(diff_g_q);
      sq_b_q   <= square_diff(diff_b_q);
      thr2_q   <= thr1_q;
      hit_q    <= (sum < thr2_q);
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/multi_corner_tracker.sv
// Multi-channel colour target tracker. Each pixel is compared against NUM_CH
// target colours; per frame the tracker accumulates, for every channel, the
// bounding box and hit count of matching pixels and publishes them after eof.
// Optional feature: define CORNER_CENTROID_EN to build per-channel x/y
// coordinate-sum accumulators on res_sum_x/res_sum_y (tied to zero otherwise).
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   in_valid, in_sof, in_eof      pixel qualifier and frame markers
//   in_x, in_y, r, g, b           pixel coordinates and colour
//   target_rgb, threshold         per-channel target colour and threshold
//   hit_valid, hit                per-pixel match, 3 cycles after the pixel
//   res_valid, res_abort          frame published / frame aborted pulses
//   res_found                     per-channel count >= MIN_COUNT
//   res_xmin/xmax/ymin/ymax       per-channel bounding box (zero if not found)
//   res_count                     per-channel hit count
//   res_sum_x, res_sum_y          per-channel coordinate sums (zero if not found)
module multi_corner_tracker
  import corner_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MIN_COUNT = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  input  logic                                in_sof,
  input  logic                                in_eof,
  input  logic [COORD_W-1:0]                  in_x,
  input  logic [COORD_W-1:0]                  in_y,
  input  logic [COLOR_W-1:0]                  r,
  input  logic [COLOR_W-1:0]                  g,
  input  logic [COLOR_W-1:0]                  b,
  input  logic [RGB_W*NUM_CH-1:0]             target_rgb,
  input  logic [SUM_W*NUM_CH-1:0]             threshold,
  output logic                                hit_valid,
  output logic [NUM_CH-1:0]                   hit,
  output logic                                res_valid,
  output logic                                res_abort,
  output logic [NUM_CH-1:0]                   res_found,
  output logic [COORD_W*NUM_CH-1:0]           res_xmin,
  output logic [COORD_W*NUM_CH-1:0]           res_xmax,
  output logic [COORD_W*NUM_CH-1:0]           res_ymin,
  output logic [COORD_W*NUM_CH-1:0]           res_ymax,
  output logic [CNT_W*NUM_CH-1:0]             res_count,
  output logic [(2*COORD_W+CNT_W)*NUM_CH-1:0] res_sum_x,
  output logic [(2*COORD_W+CNT_W)*NUM_CH-1:0] res_sum_y
);

  localparam int unsigned SUMXY_W = 2*COORD_W + CNT_W;

  // Sideband carried alongside the pixel through the three distance stages.
  logic [2:0]         vld_q, sof_q, eof_q;
  logic [COORD_W-1:0] x_q [3];
  logic [COORD_W-1:0] y_q [3];
  logic [NUM_CH-1:0]  hit_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      sof_q <= '0;
      eof_q <= '0;
      for (int i = 0; i < 3; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      vld_q  <= {vld_q[1:0], in_valid};
      sof_q  <= {sof_q[1:0], in_valid & in_sof};
      eof_q  <= {eof_q[1:0], in_valid & in_eof};
      x_q[0] <= in_x;
      y_q[0] <= in_y;
      for (int i = 1; i < 3; i++) begin
        x_q[i] <= x_q[i-1];
        y_q[i] <= y_q[i-1];
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    color_dist_pipe u_pipe (
      .clk       (clk),
      .reset     (reset),
      .r         (r),
      .g         (g),
      .b         (b),
      .target    (target_rgb[RGB_W*k +: RGB_W]),
      .threshold (threshold[SUM_W*k +: SUM_W]),
      .hit       (hit_raw[k])
    );
  end

  logic               v3, sof3, eof3;
  logic [COORD_W-1:0] x3, y3;

  assign v3        = vld_q[2];
  assign sof3      = sof_q[2];
  assign eof3      = eof_q[2];
  assign x3        = x_q[2];
  assign y3        = y_q[2];
  assign hit_valid = v3;
  assign hit       = hit_raw & {NUM_CH{v3}};

  // Frame FSM, driven by the stage-3 pixel.
  corner_state_e state_q, state_d;
  logic          acc_clear, acc_fold, abort, publish;

  always_comb begin
    state_d   = state_q;
    acc_clear = 1'b0;
    acc_fold  = 1'b0;
    abort     = 1'b0;
    publish   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (v3 && sof3) begin
          acc_clear = 1'b1;
          acc_fold  = 1'b1;
          state_d   = eof3 ? StPublish : StAccum;
        end
      end
      StAccum: begin
        if (v3) begin
          acc_fold = 1'b1;
          // A new sof without an eof restarts the frame.
          if (sof3) begin
            acc_clear = 1'b1;
            abort     = 1'b1;
          end
          if (eof3) state_d = StPublish;
        end
      end
      StPublish: begin
        publish = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Per-channel box and count accumulators.
  logic [COORD_W-1:0] xmin_q [NUM_CH];
  logic [COORD_W-1:0] xmax_q [NUM_CH];
  logic [COORD_W-1:0] ymin_q [NUM_CH];
  logic [COORD_W-1:0] ymax_q [NUM_CH];
  logic [CNT_W-1:0]   cnt_q  [NUM_CH];
  logic [COORD_W-1:0] xmin_d [NUM_CH];
  logic [COORD_W-1:0] xmax_d [NUM_CH];
  logic [COORD_W-1:0] ymin_d [NUM_CH];
  logic [COORD_W-1:0] ymax_d [NUM_CH];
  logic [CNT_W-1:0]   cnt_d  [NUM_CH];
  logic [NUM_CH-1:0]  found;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (acc_clear) begin
        xmin_d[k] = '1;
        xmax_d[k] = '0;
        ymin_d[k] = '1;
        ymax_d[k] = '0;
        cnt_d[k]  = '0;
      end else begin
        xmin_d[k] = xmin_q[k];
        xmax_d[k] = xmax_q[k];
        ymin_d[k] = ymin_q[k];
        ymax_d[k] = ymax_q[k];
        cnt_d[k]  = cnt_q[k];
      end
      if (acc_fold && hit_raw[k]) begin
        if (x3 < xmin_d[k]) xmin_d[k] = x3;
        if (x3 > xmax_d[k]) xmax_d[k] = x3;
        if (y3 < ymin_d[k]) ymin_d[k] = y3;
        if (y3 > ymax_d[k]) ymax_d[k] = y3;
        if (cnt_d[k] != '1) cnt_d[k] = cnt_d[k] + CNT_W'(1);
      end
      found[k] = (cnt_q[k] >= CNT_W'(MIN_COUNT));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      res_valid <= 1'b0;
      res_abort <= 1'b0;
      res_found <= '0;
      res_xmin  <= '0;
      res_xmax  <= '0;
      res_ymin  <= '0;
      res_ymax  <= '0;
      res_count <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        xmin_q[k] <= '0;
        xmax_q[k] <= '0;
        ymin_q[k] <= '0;
        ymax_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      res_valid <= publish;
      res_abort <= abort;
      for (int k = 0; k < NUM_CH; k++) begin
        xmin_q[k] <= xmin_d[k];
        xmax_q[k] <= xmax_d[k];
        ymin_q[k] <= ymin_d[k];
        ymax_q[k] <= ymax_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
      if (publish) begin
        res_found <= found;
        for (int k = 0; k < NUM_CH; k++) begin
          res_xmin[COORD_W*k +: COORD_W] <= found[k] ? xmin_q[k] : '0;
          res_xmax[COORD_W*k +: COORD_W] <= found[k] ? xmax_q[k] : '0;
          res_ymin[COORD_W*k +: COORD_W] <= found[k] ? ymin_q[k] : '0;
          res_ymax[COORD_W*k +: COORD_W] <= found[k] ? ymax_q[k] : '0;
          res_count[CNT_W*k +: CNT_W]    <= cnt_q[k];
        end
      end
    end
  end

`ifdef CORNER_CENTROID_EN
  logic [SUMXY_W-1:0] sx_q [NUM_CH];
  logic [SUMXY_W-1:0] sy_q [NUM_CH];
  logic [SUMXY_W-1:0] sx_d [NUM_CH];
  logic [SUMXY_W-1:0] sy_d [NUM_CH];

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      sx_d[k] = acc_clear ? '0 : sx_q[k];
      sy_d[k] = acc_clear ? '0 : sy_q[k];
      if (acc_fold && hit_raw[k]) begin
        sx_d[k] = sx_d[k] + SUMXY_W'(x3);
        sy_d[k] = sy_d[k] + SUMXY_W'(y3);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_sum_x <= '0;
      res_sum_y <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        sx_q[k] <= '0;
        sy_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        sx_q[k] <= sx_d[k];
        sy_q[k] <= sy_d[k];
      end
      if (publish) begin
        for (int k = 0; k < NUM_CH; k++) begin
          res_sum_x[SUMXY_W*k +: SUMXY_W] <= found[k] ? sx_q[k] : '0;
          res_sum_y[SUMXY_W*k +: SUMXY_W] <= found[k] ? sy_q[k] : '0;
        end
      end
    end
  end
`else
  assign res_sum_x = '0;
  assign res_sum_y = '0;
`endif

endmodule
